// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full adder walks a WIDTH-bit operand pair LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.

module FA (
  output logic cout,
  output logic s,
  input  logic x,
  input  logic y,
  input  logic cin
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ripin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             ripout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] c_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             ripout_reg;
  logic             fa_s;
  logic             fa_cout;

  FA fa_inst (fa_cout, fa_s, opa_reg[0], opb_reg[0], carry_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_reg == LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // Accepting here gives back-to-back adds every WIDTH+1 cycles.
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa_reg    <= '0;
      opb_reg    <= '0;
      res_reg    <= '0;
      c_reg      <= '0;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      ripout_reg <= 1'b0;
    end else if (load) begin
      opa_reg   <= a;
      opb_reg   <= b;
      carry_reg <= ripin;
      cnt_reg   <= '0;
    end else if (step) begin
      opa_reg   <= opa_reg >> 1;
      opb_reg   <= opb_reg >> 1;
      carry_reg <= fa_cout;
      res_reg   <= {fa_s, res_reg[WIDTH-1:1]};
      cnt_reg   <= last ? '0 : cnt_reg + CW'(1);
      // The final sum bit is merged straight into c so it is valid with done.
      if (last) begin
        c_reg      <= {fa_s, res_reg[WIDTH-1:1]};
        ripout_reg <= fa_cout;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic msb_cin_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      msb_cin_reg <= 1'b0;
    end else if (step && last) begin
      msb_cin_reg <= carry_reg;
    end
  end

  assign ovf = msb_cin_reg ^ ripout_reg;
`endif

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign c      = c_reg;
  assign ripout = ripout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: driver pushes a+b+ripin results,
// a negedge monitor pops and compares on every done pulse.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rin;
    logic [W:0]   sum;
    logic         ovf;
    int           done_cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ripin;
  logic         busy;
  logic         done;
  logic [W-1:0] c;
  logic         ripout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   txn    = 0;
  exp_t q[$];
  exp_t mon_e;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .ripin  (ripin),
    .busy   (busy),
    .done   (done),
    .c      (c),
    .ripout (ripout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer addition; signed overflow from operand/result signs.
  task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic er);
    exp_t e;
    e.a        = ea;
    e.b        = eb;
    e.rin      = er;
    e.sum      = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, er};
    e.ovf      = (ea[W-1] == eb[W-1]) && (e.sum[W-1] != ea[W-1]);
    e.done_cyc = cyc + W;
    q.push_back(e);
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic add(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic er);
    @(negedge clk);
    a     = ea;
    b     = eb;
    ripin = er;
    start = 1'b1;
    @(negedge clk);
    push_exp(ea, eb, er);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: outstanding=%0d busy=%b, required no outstanding add", q.size(), busy);
      q.delete();
    end
  endtask

  task automatic check_out(input string name, input logic [W-1:0] ec, input logic er);
    checks++;
    if (c !== ec || ripout !== er) begin
      errors++;
      $display("FAIL %s: c=%h ripout=%b, required c=%h ripout=%b", name, c, ripout, ec, er);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: cycle %0d c=%h ripout=%b, required no done", cyc, c, ripout);
        end else begin
          mon_e = q.pop_front();
          txn++;
          if (cyc != mon_e.done_cyc) begin
            errors++;
            $display("FAIL done_timing: done at cycle %0d, required cycle %0d", cyc, mon_e.done_cyc);
          end
          checks++;
          if ({ripout, c} !== mon_e.sum) begin
            errors++;
            $display("FAIL sum: a=%h b=%h cin=%b got {ripout,c}=%h, required %h",
                     mon_e.a, mon_e.b, mon_e.rin, {ripout, c}, mon_e.sum);
          end
`ifdef SERIAL_ADD_OVF_EN
          checks++;
          if (ovf !== mon_e.ovf) begin
            errors++;
            $display("FAIL ovf: a=%h b=%h cin=%b got %b, required %b",
                     mon_e.a, mon_e.b, mon_e.rin, ovf, mon_e.ovf);
          end
`endif
          $display("txn %0d: a=%h b=%h cin=%b -> c=%h ripout=%b at cycle %0d",
                   txn, mon_e.a, mon_e.b, mon_e.rin, c, ripout, cyc);
        end
      end else if (q.size() != 0 && cyc > q[0].done_cyc) begin
        checks++;
        errors++;
        $display("FAIL done_missing: no done by cycle %0d, required at cycle %0d", cyc, q[0].done_cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    ripin = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_out("reset_outputs", 8'h00, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check_bit("reset_ovf", ovf, 1'b0);
`endif
    rst = 1'b0;

    // Case 1 with explicit busy window.
    add(8'h0F, 8'h01, 1'b0);
    for (int i = 0; i < W; i++) begin
      check_bit("busy_window", busy, 1'b1);
      @(negedge clk);
    end
    check_bit("busy_after_run", busy, 1'b0);
    check_bit("done_pulse", done, 1'b1);
    wait_drain();
    check_out("case1", 8'h10, 1'b0);

    add(8'hFF, 8'h01, 1'b0);
    wait_drain();
    check_out("case2", 8'h00, 1'b1);

    add(8'h7F, 8'h00, 1'b1);
    wait_drain();
    check_out("case3", 8'h80, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check_bit("case3_ovf", ovf, 1'b1);
`endif

    // Start during RUN must be ignored.
    add(8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    a     = 8'hAA;
    b     = 8'h55;
    ripin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    check_out("ignored_start", 8'h46, 1'b0);

    // Back-to-back: start held across DONE.
    add(8'h20, 8'h21, 1'b0);
    repeat (W - 1) @(negedge clk);
    a     = 8'h01;
    b     = 8'h02;
    ripin = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    push_exp(8'h01, 8'h02, 1'b0);
    start = 1'b0;
    wait_drain();
    check_out("back_to_back", 8'h03, 1'b0);

    // Reset mid-RUN aborts silently.
    add(8'h0F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    check_bit("midrun_rst_busy", busy, 1'b0);
    check_bit("midrun_rst_done", done, 1'b0);
    check_out("midrun_rst_outputs", 8'h00, 1'b0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    add(8'h33, 8'h44, 1'b1);
    wait_drain();
    check_out("after_rst", 8'h78, 1'b0);

    // Randomized adds, some with ignored mid-run start pulses.
    for (int t = 0; t < 300; t++) begin
      add(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(W - 3, 1)) @(negedge clk);
        a     = W'($urandom);
        b     = W'($urandom);
        ripin = 1'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_drain();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
